// File: rtl/dcache_d1_pkg.sv
// rtl/dcache_d1_pkg.sv - shared data cache geometry and victim record for the D1 stage
package dcache_d1_pkg;

   localparam int DC_DATA_WIDTH  = 32;
   localparam int DC_ADDR_WIDTH  = 32;
   localparam int DC_CACHE_SIZE  = 1024;
   localparam int DC_LINE_SIZE   = 32;
   localparam int DC_WAY_COUNT   = 1;

   localparam int DC_WORD_SIZE    = DC_DATA_WIDTH / 8;
   localparam int DC_LINE_WIDTH   = DC_LINE_SIZE * 8;
   localparam int DC_OFFSET_WIDTH = $clog2(DC_LINE_SIZE);
   localparam int DC_SET_COUNT    = DC_CACHE_SIZE / DC_LINE_SIZE / DC_WAY_COUNT;
   localparam int DC_INDEX_WIDTH  = $clog2(DC_SET_COUNT);
   localparam int DC_TAG_WIDTH    = DC_ADDR_WIDTH - DC_INDEX_WIDTH - DC_OFFSET_WIDTH;

   typedef struct packed {
      logic                     valid;
      logic                     dirty;
      logic [DC_TAG_WIDTH-1:0]  tag;
      logic [DC_LINE_WIDTH-1:0] data;
   } dcache_victim_t;

endpackage

// File: rtl/dcache_d1_line_merge.sv
// rtl/dcache_d1_line_merge.sv - byte-enable store merge into a line plus word extraction
module dcache_d1_line_merge #(
   parameter int LINE_SIZE    = 32,
   parameter int WORD_SIZE    = 4,
   parameter int OFFSET_WIDTH = $clog2(LINE_SIZE)
) (
   input  logic [LINE_SIZE*8-1:0]  line,
   input  logic [OFFSET_WIDTH-1:0] offset,
   input  logic [WORD_SIZE-1:0]    byte_sel,
   input  logic [WORD_SIZE*8-1:0]  data,
   output logic [LINE_SIZE*8-1:0]  merged,
   output logic [WORD_SIZE*8-1:0]  word,
   output logic [WORD_SIZE*8-1:0]  merged_word
);

   localparam logic [OFFSET_WIDTH:0] LINE_END = (OFFSET_WIDTH+1)'(LINE_SIZE);

   // Bytes that would fall past the end of the line are dropped on write and read as zero.
   always_comb begin
      merged      = line;
      word        = '0;
      merged_word = '0;
      for (int k = 0; k < WORD_SIZE; k++) begin
         logic [OFFSET_WIDTH:0] pos;
         pos = {1'b0, offset} + (OFFSET_WIDTH+1)'(k);
         if (pos < LINE_END && byte_sel[k]) begin
            merged[{pos[OFFSET_WIDTH-1:0], 3'b000} +: 8] = data[k*8 +: 8];
         end
      end
      for (int k = 0; k < WORD_SIZE; k++) begin
         logic [OFFSET_WIDTH:0] pos;
         pos = {1'b0, offset} + (OFFSET_WIDTH+1)'(k);
         if (pos < LINE_END) begin
            word[k*8 +: 8]        = line[{pos[OFFSET_WIDTH-1:0], 3'b000} +: 8];
            merged_word[k*8 +: 8] = merged[{pos[OFFSET_WIDTH-1:0], 3'b000} +: 8];
         end
      end
   end

endmodule

// File: rtl/dcache_d1.sv
// rtl/dcache_d1.sv - direct-mapped tag/state/data arrays, tag compare, store merge and fill/victim
module dcache_d1
   import dcache_d1_pkg::*;
#(
   parameter int OPTN_DATA_WIDTH    = DC_DATA_WIDTH,
   parameter int OPTN_ADDR_WIDTH    = DC_ADDR_WIDTH,
   parameter int OPTN_DC_CACHE_SIZE = DC_CACHE_SIZE,
   parameter int OPTN_DC_LINE_SIZE  = DC_LINE_SIZE,
   parameter int OPTN_DC_WAY_COUNT  = DC_WAY_COUNT,
   localparam int WORD_SIZE    = OPTN_DATA_WIDTH / 8,
   localparam int LINE_WIDTH   = OPTN_DC_LINE_SIZE * 8,
   localparam int OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE),
   localparam int SET_COUNT    = OPTN_DC_CACHE_SIZE / OPTN_DC_LINE_SIZE,
   localparam int INDEX_WIDTH  = $clog2(SET_COUNT),
   localparam int TAG_WIDTH    = OPTN_ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_wr_en,
   input  logic [TAG_WIDTH-1:0]       i_tag,
   input  logic [INDEX_WIDTH-1:0]     i_index,
   input  logic [OFFSET_WIDTH-1:0]    i_offset,
   input  logic [WORD_SIZE-1:0]       i_byte_sel,
   input  logic [OPTN_DATA_WIDTH-1:0] i_data,
   input  logic                       i_valid,
   input  logic                       i_dirty,
   input  logic                       i_fill,
   input  logic [LINE_WIDTH-1:0]      i_fill_data,
   output logic                       o_hit,
   output logic [OPTN_DATA_WIDTH-1:0] o_data,
   output logic                       o_victim_valid,
   output logic                       o_victim_dirty,
   output logic [TAG_WIDTH-1:0]       o_victim_tag,
   output logic [LINE_WIDTH-1:0]      o_victim_data
);

   generate
      if (OPTN_DC_WAY_COUNT != 1) begin : g_way_check
         $error("dcache_d1 supports only a direct-mapped cache (OPTN_DC_WAY_COUNT must be 1)");
      end
      if (TAG_WIDTH != DC_TAG_WIDTH || LINE_WIDTH != DC_LINE_WIDTH) begin : g_geom_check
         $error("dcache_d1 geometry disagrees with dcache_d1_pkg victim record");
      end
   endgenerate

   logic [TAG_WIDTH-1:0]       tag_q   [SET_COUNT];
   logic [LINE_WIDTH-1:0]      data_q  [SET_COUNT];
   logic [SET_COUNT-1:0]       valid_q;
   logic [SET_COUNT-1:0]       dirty_q;

   logic                       hit;
   logic                       store_en;
   logic [LINE_WIDTH-1:0]      base_line;
   logic [LINE_WIDTH-1:0]      merged_line;
   logic [OPTN_DATA_WIDTH-1:0] pre_word;
   logic [OPTN_DATA_WIDTH-1:0] merged_word;
   dcache_victim_t             victim_next;
   dcache_victim_t             victim_q;

   assign hit       = valid_q[i_index] & (tag_q[i_index] == i_tag);
   // A fill carries i_tag, so a same-cycle store always lands in the incoming line.
   assign store_en  = i_wr_en & (i_fill | hit);
   assign base_line = i_fill ? i_fill_data : data_q[i_index];

   dcache_d1_line_merge #(
      .LINE_SIZE    (OPTN_DC_LINE_SIZE),
      .WORD_SIZE    (WORD_SIZE),
      .OFFSET_WIDTH (OFFSET_WIDTH)
   ) u_line_merge (
      .line        (base_line),
      .offset      (i_offset),
      .byte_sel    (store_en ? i_byte_sel : '0),
      .data        (i_data),
      .merged      (merged_line),
      .word        (pre_word),
      .merged_word (merged_word)
   );

   always_comb begin
      victim_next.valid = i_fill & valid_q[i_index] & (tag_q[i_index] != i_tag);
      victim_next.dirty = i_fill & valid_q[i_index] & dirty_q[i_index];
      victim_next.tag   = tag_q[i_index];
      victim_next.data  = data_q[i_index];
   end

   // Tag and data arrays carry no reset; only the state bits are cleared.
   always_ff @(posedge clk) begin
      if (i_fill) begin
         tag_q[i_index]  <= i_tag;
         data_q[i_index] <= merged_line;
      end else if (store_en) begin
         data_q[i_index] <= merged_line;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (i_fill) begin
         valid_q[i_index] <= i_valid;
         dirty_q[i_index] <= i_dirty | i_wr_en;
      end else if (store_en) begin
         dirty_q[i_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_hit    <= 1'b0;
         o_data   <= '0;
         victim_q <= '0;
      end else begin
         o_hit    <= i_fill ? i_valid : hit;
         o_data   <= i_fill ? merged_word : pre_word;
         victim_q <= victim_next;
      end
   end

   assign o_victim_valid = victim_q.valid;
   assign o_victim_dirty = victim_q.dirty;
   assign o_victim_tag   = victim_q.tag;
   assign o_victim_data  = victim_q.data;

endmodule

// File: tb/tb_dcache_d1.sv
// tb/tb_dcache_d1.sv - scoreboard bench for dcache_d1 with directed vectors
module tb_dcache_d1;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_wr_en;
   logic [21:0]  i_tag;
   logic [4:0]   i_index;
   logic [4:0]   i_offset;
   logic [3:0]   i_byte_sel;
   logic [31:0]  i_data;
   logic         i_valid;
   logic         i_dirty;
   logic         i_fill;
   logic [255:0] i_fill_data;
   logic         o_hit;
   logic [31:0]  o_data;
   logic         o_victim_valid;
   logic         o_victim_dirty;
   logic [21:0]  o_victim_tag;
   logic [255:0] o_victim_data;

   dcache_d1 dut (
      .clk            (clk),
      .rst            (rst),
      .i_wr_en        (i_wr_en),
      .i_tag          (i_tag),
      .i_index        (i_index),
      .i_offset       (i_offset),
      .i_byte_sel     (i_byte_sel),
      .i_data         (i_data),
      .i_valid        (i_valid),
      .i_dirty        (i_dirty),
      .i_fill         (i_fill),
      .i_fill_data    (i_fill_data),
      .o_hit          (o_hit),
      .o_data         (o_data),
      .o_victim_valid (o_victim_valid),
      .o_victim_dirty (o_victim_dirty),
      .o_victim_tag   (o_victim_tag),
      .o_victim_data  (o_victim_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      int           stamp;
      bit           chk_hit;
      logic         hit;
      logic [31:0]  data;
      logic [31:0]  dmask;
      logic         vvalid;
      logic         vdirty;
      bit           chk_vt;
      logic [21:0]  vtag;
      logic [255:0] vdata;
   } exp_t;

   exp_t queue_exp[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input string field, input logic [255:0] act,
                      input logic [255:0] exp, input logic [255:0] mask);
      checks++;
      if ((act & mask) !== (exp & mask)) begin
         errors++;
         $display("FAIL %s.%s actual=%h required=%h", name, field, act & mask, exp & mask);
      end
   endtask

   // Monitor: outputs registered at posedge N are compared at the following negedge.
   always @(negedge clk) begin
      while (queue_exp.size() > 0 && queue_exp[0].stamp == cyc - 1) begin
         exp_t e;
         e = queue_exp.pop_front();
         if (e.chk_hit) chk(e.name, "hit", 256'(o_hit), 256'(e.hit), 256'h1);
         if (e.dmask != 0) chk(e.name, "data", 256'(o_data), 256'(e.data), 256'(e.dmask));
         chk(e.name, "victim_valid", 256'(o_victim_valid), 256'(e.vvalid), 256'h1);
         chk(e.name, "victim_dirty", 256'(o_victim_dirty), 256'(e.vdirty), 256'h1);
         if (e.chk_vt) begin
            chk(e.name, "victim_tag", 256'(o_victim_tag), 256'(e.vtag), {256{1'b1}});
            chk(e.name, "victim_data", o_victim_data, e.vdata, {256{1'b1}});
         end
      end
   end

   function automatic exp_t mk(input string name, input bit chk_hit, input logic hit,
                               input logic [31:0] data, input logic [31:0] dmask,
                               input logic vvalid, input logic vdirty);
      exp_t e;
      e.name = name; e.stamp = 0; e.chk_hit = chk_hit; e.hit = hit;
      e.data = data; e.dmask = dmask; e.vvalid = vvalid; e.vdirty = vdirty;
      e.chk_vt = 0; e.vtag = '0; e.vdata = '0;
      return e;
   endfunction

   task automatic issue(input logic r, input logic wr, input logic [21:0] tag, input logic [4:0] idx,
                        input logic [4:0] off, input logic [3:0] bsel, input logic [31:0] d,
                        input logic fill, input logic v, input logic dt, input logic [255:0] fd,
                        input exp_t e);
      rst = r; i_wr_en = wr; i_tag = tag; i_index = idx; i_offset = off; i_byte_sel = bsel;
      i_data = d; i_fill = fill; i_valid = v; i_dirty = dt; i_fill_data = fd;
      e.stamp = cyc;
      queue_exp.push_back(e);
      @(negedge clk);
   endtask

   logic [255:0] line_a, line_a_mod, line_b, line_c, line_c_mod, zero_line;
   exp_t e;

   initial begin
      for (int i = 0; i < 32; i++) begin
         line_a[i*8 +: 8] = 8'(i);
         line_c[i*8 +: 8] = 8'(8'h40 + i);
      end
      line_b     = {32{8'h55}};
      zero_line  = '0;
      line_a_mod = line_a;
      line_a_mod[6*8 +: 8]  = 8'hAA;
      line_a_mod[31*8 +: 8] = 8'h44;
      line_c_mod = line_c;
      line_c_mod[15:0] = 16'hBEEF;

      // 1: reset and a cold lookup
      e = mk("rst0", 1, 0, 0, 32'hFFFFFFFF, 0, 0); e.chk_vt = 1;
      issue(1, 0, 22'h1, 5'd3, 5'd0, 4'hF, 0, 0, 0, 0, zero_line, e);
      e = mk("rst1", 1, 0, 0, 32'hFFFFFFFF, 0, 0); e.chk_vt = 1;
      issue(1, 1, 22'h1, 5'd3, 5'd0, 4'hF, 32'h12345678, 0, 0, 0, zero_line, e);
      issue(0, 0, 22'h1, 5'd3, 5'd0, 4'hF, 0, 0, 0, 0, zero_line, mk("cold", 1, 0, 0, 0, 0, 0));

      // 2: fill then load
      issue(0, 0, 22'h1, 5'd3, 5'd0, 4'h0, 0, 1, 1, 0, line_a, mk("fill3", 0, 0, 0, 0, 0, 0));
      issue(0, 0, 22'h1, 5'd3, 5'd4, 4'hF, 0, 0, 0, 0, zero_line,
            mk("load4", 1, 1, 32'h07060504, 32'hFFFFFFFF, 0, 0));

      // 3: store, read-back, line-end boundary
      issue(0, 1, 22'h1, 5'd3, 5'd6, 4'h1, 32'h000000AA, 0, 0, 0, zero_line,
            mk("store6", 1, 1, 32'h09080706, 32'hFFFFFFFF, 0, 0));
      issue(0, 0, 22'h1, 5'd3, 5'd4, 4'hF, 0, 0, 0, 0, zero_line,
            mk("load4b", 1, 1, 32'h07AA0504, 32'hFFFFFFFF, 0, 0));
      issue(0, 0, 22'h1, 5'd3, 5'd30, 4'hF, 0, 0, 0, 0, zero_line,
            mk("load30", 1, 1, 32'h00001F1E, 32'hFFFFFFFF, 0, 0));
      issue(0, 1, 22'h1, 5'd3, 5'd31, 4'hF, 32'h11223344, 0, 0, 0, zero_line,
            mk("store31", 1, 1, 32'h0000001F, 32'hFFFFFFFF, 0, 0));
      issue(0, 0, 22'h1, 5'd3, 5'd28, 4'hF, 0, 0, 0, 0, zero_line,
            mk("load28", 1, 1, 32'h441E1D1C, 32'hFFFFFFFF, 0, 0));

      // 4: evicting fill
      e = mk("evict3", 0, 0, 0, 0, 1, 1); e.chk_vt = 1; e.vtag = 22'h1; e.vdata = line_a_mod;
      issue(0, 0, 22'h2, 5'd3, 5'd0, 4'h0, 0, 1, 1, 0, line_b, e);
      issue(0, 0, 22'h1, 5'd3, 5'd0, 4'hF, 0, 0, 0, 0, zero_line, mk("oldtag", 1, 0, 0, 0, 0, 0));
      issue(0, 0, 22'h2, 5'd3, 5'd0, 4'hF, 0, 0, 0, 0, zero_line,
            mk("newtag", 1, 1, 32'h55555555, 32'hFFFFFFFF, 0, 0));

      // 5: fill merged with a same-cycle store
      issue(0, 1, 22'h5, 5'd7, 5'd0, 4'h3, 32'h0000BEEF, 1, 1, 0, line_c,
            mk("fillst7", 1, 1, 32'h4342BEEF, 32'hFFFFFFFF, 0, 0));

      // 6: store miss, then eviction proves line unchanged and dirty, then reset
      issue(0, 1, 22'h9, 5'd7, 5'd0, 4'hF, 32'hDEADBEEF, 0, 0, 0, zero_line,
            mk("stmiss", 1, 0, 0, 0, 0, 0));
      issue(0, 0, 22'h5, 5'd7, 5'd0, 4'hF, 0, 0, 0, 0, zero_line,
            mk("load7", 1, 1, 32'h4342BEEF, 32'hFFFFFFFF, 0, 0));
      e = mk("evict7", 0, 0, 0, 0, 1, 1); e.chk_vt = 1; e.vtag = 22'h5; e.vdata = line_c_mod;
      issue(0, 0, 22'h6, 5'd7, 5'd0, 4'h0, 0, 1, 1, 0, zero_line, e);
      e = mk("rstfill", 1, 0, 0, 32'hFFFFFFFF, 0, 0); e.chk_vt = 1;
      issue(1, 1, 22'h6, 5'd7, 5'd0, 4'hF, 32'h01020304, 1, 1, 1, line_b, e);
      issue(0, 0, 22'h6, 5'd7, 5'd0, 4'hF, 0, 0, 0, 0, zero_line, mk("postrst7", 1, 0, 0, 0, 0, 0));
      issue(0, 0, 22'h2, 5'd3, 5'd0, 4'hF, 0, 0, 0, 0, zero_line, mk("postrst3", 1, 0, 0, 0, 0, 0));
      issue(0, 0, 22'h7, 5'd7, 5'd0, 4'h0, 0, 1, 1, 0, line_a, mk("fillclean", 0, 0, 0, 0, 0, 0));

      rst = 0; i_wr_en = 0; i_fill = 0;
      for (int n = 0; n < 5 && queue_exp.size() > 0; n++) @(negedge clk);
      if (queue_exp.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", queue_exp.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
